c1541_img_server: RTL
=====================

// Module: c1541_img_server
// PURPOSE
//  Responder end of the drive's SD block interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*).
//  Serves 512-byte block reads/writes from a disk image held in byte-wide external memory
//  (SDRAM/DDR bridge), so the 1541 track engine runs without the HPS SD path.
//  Sits between the c1541_sd requester and the memory arbiter port.
// PARAMETERS
//  MEM_AW   24   byte address width of image memory
//  BLK_LOG2 9    log2 block size in bytes (512); sd_buff_addr width = BLK_LOG2
// PORTS
//  clk32        in   1       system clock; sole clock domain
//  reset        in   1       asynchronous, active-high reset
//  img_blocks   in   MEM_AW-BLK_LOG2  image size in blocks (0 = no image)
//  img_readonly in   1       1 = discard writes (still acked)
//  sd_lba       in   32      block number, sampled at request accept
//  sd_rd        in   1       read request level; held by requester until sd_ack=1
//  sd_wr        in   1       write request level; same rules
//  sd_ack       out  1       high for entire transfer
//  sd_buff_addr out  9       byte index within block
//  sd_buff_dout out  8       read data toward requester buffer
//  sd_buff_wr   out  1       1-cycle strobe: sd_buff_dout valid at sd_buff_addr
//  sd_buff_din  in   8       write data from requester buffer, 1-cycle latency after addr
//  mem_addr     out  MEM_AW  byte address
//  mem_rd       out  1       read request, held until mem_ready
//  mem_wr       out  1       write request, held until mem_ready
//  mem_din      out  8       write data
//  mem_dout     in   8       read data, valid when mem_ready=1
//  mem_ready    in   1       1-cycle completion pulse
// BEHAVIOUR
//  Reset (async): state IDLE, cnt=0; sd_ack, sd_buff_wr, mem_rd, mem_wr = 0;
//   sd_buff_addr, sd_buff_dout, mem_addr, mem_din = 0. Reset mid-transfer aborts silently.
//  IDLE: sd_rd=1 -> latch lba, dir=RD, oor=(lba>=img_blocks), sd_ack=1 next cycle;
//   else sd_wr=1 -> same with dir=WR. sd_rd&sd_wr together: read wins, write ignored.
//  Base = lba[MEM_AW-BLK_LOG2-1:0] << BLK_LOG2; mem_addr = base | cnt (no carry into lba).
//  Read: RD_MEM: if oor, skip memory, data=8'h00; else mem_rd=1 until mem_ready, capture
//   mem_dout. RD_PUT: sd_buff_addr=cnt, sd_buff_dout=data, sd_buff_wr=1 one cycle.
//   cnt==511 -> DONE else cnt+1 -> RD_MEM. Min 3 clk/byte with 1-cycle memory.
//  Write: WR_ADDR: sd_buff_addr=cnt. WR_LAT: capture sd_buff_din next edge.
//   WR_MEM: if oor|img_readonly skip; else mem_wr=1, mem_din=byte until mem_ready.
//   cnt==511 -> DONE else cnt+1 -> WR_ADDR.
//  DONE: sd_ack=0, cnt=0 -> IDLE. Requests re-sampled only in IDLE; a request still high
//   there starts a new transfer (requester must drop rd/wr once ack seen).
//  Request changes during transfer are ignored; sd_lba sampled once.
//  mem_rd and mem_wr never both 1; never asserted when sd_ack=0.
//  cnt 9-bit; wrap 511->0 only via DONE.
// STRUCTURE
//  Shared package c1541_pkg: state enum (IDLE,RD_MEM,RD_PUT,WR_ADDR,WR_LAT,WR_MEM,DONE),
//   BLK_BYTES=512 constant. Single flat FSM module; no sub-module needed — the memory
//   handshake is 2 states and does not warrant its own block.
// TESTING
//  Read lba=2, mem[x]=x[7:0]^8'h5A, mem_ready 1 cycle -> 512 sd_buff_wr strobes, addr 0..511,
//   dout=(0x400+i)^0x5A, ack falls after last strobe.
//  Write lba=3, requester buf[i]=~i -> mem[0x600+i]=~i[7:0] for all 512; mem_addr stays 0x600..0x7FF.
//  img_blocks=683, read lba=700 -> no mem_rd, 512 strobes dout=00; write lba=700 -> no mem_wr, ack completes.
//  img_readonly=1, write lba=0 -> zero mem_wr pulses, memory unchanged, ack high ~1536+ clks then low.
//  sd_rd & sd_wr rise same cycle -> read transfer only; mem_ready delayed 5 cycles -> data still exact.
//  Assert reset at byte 100 of a read -> all outputs 0 async, next request restarts at addr 0.

Source files
------------

// File: rtl/c1541_pkg.sv
// Shared types for the 1541 image server: FSM state encoding and block size.
package c1541_pkg;
  localparam int BLK_BYTES = 512;

  typedef enum logic [2:0] {
    IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_LAT, WR_MEM, DONE
  } state_t;
endpackage

// File: rtl/c1541_img_server_if.sv
// Bus bundles: the drive's SD block port and the byte-wide image memory port.
interface c1541_sd_if #(parameter int BLK_LOG2 = 9);
  logic [31:0]         sd_lba;
  logic                sd_rd;
  logic                sd_wr;
  logic                sd_ack;
  logic [BLK_LOG2-1:0] sd_buff_addr;
  logic [7:0]          sd_buff_dout;
  logic                sd_buff_wr;
  logic [7:0]          sd_buff_din;

  modport master (output sd_lba, sd_rd, sd_wr, sd_buff_din,
                  input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr);
  modport slave  (input  sd_lba, sd_rd, sd_wr, sd_buff_din,
                  output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr);
endinterface

interface c1541_mem_if #(parameter int MEM_AW = 24);
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ready;

  modport master (output mem_addr, mem_rd, mem_wr, mem_din,
                  input  mem_dout, mem_ready);
  modport slave  (input  mem_addr, mem_rd, mem_wr, mem_din,
                  output mem_dout, mem_ready);
endinterface

// File: rtl/c1541_img_server.sv
// Serves 512-byte SD block reads/writes for the 1541 requester out of an image in byte-wide memory.
module c1541_img_server
  import c1541_pkg::*;
#(
  parameter int MEM_AW   = 24,
  parameter int BLK_LOG2 = 9
) (
  input  logic                       clk32,
  input  logic                       reset,
  input  logic [MEM_AW-BLK_LOG2-1:0] img_blocks,
  input  logic                       img_readonly,
  c1541_sd_if.slave                  sd,
  c1541_mem_if.master                mem
);
  localparam int LW = MEM_AW - BLK_LOG2;

  state_t              state_q, state_d;
  logic [BLK_LOG2-1:0] cnt_q, cnt_d;
  logic [LW-1:0]       lba_q, lba_d;
  logic                oor_q, oor_d;
  logic                ack_q, ack_d;
  logic                bwr_q, bwr_d;
  logic [BLK_LOG2-1:0] baddr_q, baddr_d;
  logic [7:0]          bdout_q, bdout_d;
  logic [MEM_AW-1:0]   maddr_q, maddr_d;
  logic                mrd_q, mrd_d;
  logic                mwr_q, mwr_d;
  logic [7:0]          mdin_q, mdin_d;

  logic                req_oor;
  logic                last;
  logic [BLK_LOG2-1:0] cnt_inc;

  assign req_oor = sd.sd_lba >= {{(32-LW){1'b0}}, img_blocks};
  assign last    = &cnt_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    oor_d   = oor_q;
    ack_d   = ack_q;
    bwr_d   = 1'b0;
    baddr_d = baddr_q;
    bdout_d = bdout_q;
    maddr_d = maddr_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    mdin_d  = mdin_q;
    case (state_q)
      IDLE: begin
        if (sd.sd_rd || sd.sd_wr) begin
          lba_d   = sd.sd_lba[LW-1:0];
          oor_d   = req_oor;
          cnt_d   = '0;
          ack_d   = 1'b1;
          maddr_d = {sd.sd_lba[LW-1:0], {BLK_LOG2{1'b0}}};
          if (sd.sd_rd) begin
            state_d = RD_MEM;
            mrd_d   = !req_oor;
          end else begin
            state_d = WR_ADDR;
            baddr_d = '0;
          end
        end
      end
      // mrd_q low here means the block is out of range: deliver zeros without touching memory
      RD_MEM: begin
        if (!mrd_q || mem.mem_ready) begin
          mrd_d   = 1'b0;
          bdout_d = mrd_q ? mem.mem_dout : 8'h00;
          baddr_d = cnt_q;
          bwr_d   = 1'b1;
          state_d = RD_PUT;
        end
      end
      RD_PUT: begin
        if (last) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_inc;
          maddr_d = {lba_q, cnt_inc};
          mrd_d   = !oor_q;
          state_d = RD_MEM;
        end
      end
      WR_ADDR: state_d = WR_LAT;
      WR_LAT: begin
        mdin_d  = sd.sd_buff_din;
        mwr_d   = !(oor_q || img_readonly);
        state_d = WR_MEM;
      end
      WR_MEM: begin
        if (!mwr_q || mem.mem_ready) begin
          mwr_d = 1'b0;
          if (last) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_inc;
            baddr_d = cnt_inc;
            maddr_d = {lba_q, cnt_inc};
            state_d = WR_ADDR;
          end
        end
      end
      DONE: begin
        ack_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lba_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      bwr_q   <= 1'b0;
      baddr_q <= '0;
      bdout_q <= '0;
      maddr_q <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      mdin_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      bwr_q   <= bwr_d;
      baddr_q <= baddr_d;
      bdout_q <= bdout_d;
      maddr_q <= maddr_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      mdin_q  <= mdin_d;
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_wr   = bwr_q;
  assign sd.sd_buff_addr = baddr_q;
  assign sd.sd_buff_dout = bdout_q;
  assign mem.mem_addr    = maddr_q;
  assign mem.mem_rd      = mrd_q;
  assign mem.mem_wr      = mwr_q;
  assign mem.mem_din     = mdin_q;
endmodule
